// File: rtl/fb_pkg.sv
// Shared types and geometry for the cell framebuffer responder.
// Cell codes are the values the sand engine stores per cell.
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_AW     = 17;

    typedef logic [7:0] cell_t;

    localparam cell_t CELL_EMPTY = 8'h00;
    localparam cell_t CELL_SAND  = 8'h01;
    localparam cell_t CELL_WALL  = 8'h02;
    localparam cell_t CELL_WATER = 8'h03;

    typedef enum logic {
        IDLE,
        RESP
    } rstate_t;

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous framebuffer RAM with registered read data.
// q only updates on a read, so it holds across write-only cycles.
module fb_ram
    import fb_pkg::*;
#(
    parameter int AW = FB_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  cell_t         wdata_i,
    output cell_t         q_o
);

    cell_t mem_q [0:FB_DEPTH-1];
    cell_t q_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            q_q <= mem_q[addr_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fb_responder.sv
// Avalon-MM framebuffer slave: render reads (2 cycles each), update writes,
// and a clear engine, all sharing one single-port RAM.
//
// state | meaning
// IDLE  | waiting for read; a read here claims the RAM for this cycle
// RESP  | readdata valid, waitrequest low; RAM free for clear/update
module fb_responder
    import fb_pkg::*;
#(
    parameter int    UAW         = FB_AW,
    parameter cell_t OOR_DATA    = 8'h00,
    parameter cell_t CLEAR_VALUE = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [22:0]    address,
    input  logic           read,
    output logic           waitrequest,
    output cell_t          readdata,
    input  logic [UAW-1:0] upd_address,
    input  logic           upd_write,
    input  cell_t          upd_writedata,
    output logic           upd_waitrequest,
    input  logic           clear_start,
    output logic           clear_busy
);

    localparam logic [22:0]    DEPTH_A  = 23'(FB_DEPTH);
    localparam logic [UAW:0]   DEPTH_U  = (UAW+1)'(FB_DEPTH);
    localparam logic [UAW-1:0] LAST_IDX = UAW'(FB_DEPTH - 1);

    rstate_t        state_q, state_d;
    logic           oor_q, oor_d;
    cell_t          rdata_q, rdata_d;
    logic           clr_busy_q, clr_busy_d;
    logic [UAW-1:0] clr_cnt_q, clr_cnt_d;

    logic           rd_claim;
    logic           rd_oor;
    logic           upd_commit;
    logic           ram_we;
    logic           ram_re;
    logic [UAW-1:0] ram_addr;
    cell_t          ram_wdata;
    cell_t          ram_q;
    cell_t          resp_data;

    assign rd_claim   = (state_q == IDLE) && read;
    assign rd_oor     = (address >= DEPTH_A);
    assign resp_data  = oor_q ? OOR_DATA : ram_q;
    assign upd_waitrequest = upd_write && (rd_claim || clr_busy_q);
    // Out-of-range update addresses are acknowledged but never reach the RAM.
    assign upd_commit = upd_write && !upd_waitrequest && ({1'b0, upd_address} < DEPTH_U);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            oor_q      <= 1'b0;
            rdata_q    <= '0;
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            oor_q      <= oor_d;
            rdata_q    <= rdata_d;
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (read) begin
                    state_d = RESP;
                    oor_d   = rd_oor;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = resp_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = clr_cnt_q;
        ram_wdata  = CLEAR_VALUE;
        clr_busy_d = clr_busy_q;
        clr_cnt_d  = clr_cnt_q;
        if (rd_claim) begin
            ram_re   = !rd_oor;
            ram_addr = address[UAW-1:0];
        end else if (clr_busy_q) begin
            ram_we = 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
                clr_busy_d = 1'b0;
                clr_cnt_d  = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end else if (upd_commit) begin
            ram_we    = 1'b1;
            ram_addr  = upd_address;
            ram_wdata = upd_writedata;
        end
        if (!clr_busy_q && clear_start) begin
            clr_busy_d = 1'b1;
            clr_cnt_d  = '0;
        end
    end

    fb_ram #(
        .AW(UAW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .q_o     (ram_q)
    );

    assign waitrequest = (state_q != RESP);
    assign readdata    = (state_q == RESP) ? resp_data : rdata_q;
    assign clear_busy  = clr_busy_q;

endmodule

// File: doc/fb_responder.md
Name: fb_responder

Overview:
Avalon-MM slave that owns the on-chip cell framebuffer and answers the renderer's pixel reads (address/read/waitrequest/readdata, 23-bit byte address, 8-bit data). A second write-only port takes cell updates from the sand simulation engine. A built-in clear engine fills the buffer with a constant value. A single-port synchronous RAM is arbitrated between three users, with render reads at highest priority.

Parameters:
FB_WIDTH, 320, cells per row
FB_HEIGHT, 240, rows
FB_DEPTH, FB_WIDTH*FB_HEIGHT (76800), number of RAM words
UAW, 17, update-port address width (covers FB_DEPTH-1)
OOR_DATA, 8'h00, data returned for reads with address >= FB_DEPTH
CLEAR_VALUE, 8'h00, value written by the clear engine

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
address  in  23  render read byte address, row-major y*FB_WIDTH+x
read  in  1  render read request
waitrequest  out  1  slave stall
readdata  out  8  render read data
upd_address  in  UAW  update write address
upd_write  in  1  update write request
upd_writedata  in  8  cell value
upd_waitrequest  out  1  update-port stall
clear_start  in  1  one-cycle pulse; starts a full clear
clear_busy  out  1  high while a clear is in progress

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All state is async-reset. RAM contents are not reset.
- Reset values: waitrequest=1, readdata=0, upd_waitrequest=0, clear_busy=0, FSM=IDLE, clear counter=0.
- Render FSM states:
  - IDLE: if read=1, issue a RAM read (or flag out-of-range when address >= FB_DEPTH) and go to RESP.
  - RESP: waitrequest=0 and readdata is valid (RAM q, or OOR_DATA if out of range). Transfer completes this cycle; return to IDLE unconditionally.
- waitrequest = (state != RESP). Every read therefore takes exactly 2 cycles, with 1 wait state, and back-to-back reads give one result every 2 cycles.
- readdata is registered; it holds its last value outside RESP.
- The master holds address and read stable while waitrequest=1. If read drops in IDLE, no transfer occurs.
- RAM arbitration, evaluated per cycle:
  1. Render read (state IDLE and read=1) owns the RAM.
  2. Clear engine (clear_busy=1) writes CLEAR_VALUE at the counter, then increments the counter.
  3. Update write.
  - A read in RESP does not use the RAM, so the RAM is free for the other users that cycle.
- upd_waitrequest = upd_write & (render read claims RAM | clear_busy). A write commits in the cycle where upd_write=1 and upd_waitrequest=0.
- upd_address >= FB_DEPTH: the write is accepted (no stall) and discarded.
- Ordering:
  - A write committed in cycle N is visible to a read issued in cycle N+1 or later.
  - If a read and a write arrive in the same cycle, the read wins and returns the old data; the write stalls one cycle.
- Clear engine:
  - clear_start while idle sets clear_busy and counter=0.
  - Each cycle the engine owns the RAM, it writes and increments the counter.
  - After writing address FB_DEPTH-1, clear_busy drops on the next edge.
  - clear_start while busy is ignored (no restart).
  - Render reads preempt clear cycles, so clear length = FB_DEPTH + number of preempted cycles.
- Reset mid-operation: the FSM returns to IDLE, any in-flight read is dropped, the clear is aborted (partially cleared RAM is acceptable), and outputs take their reset values.
- Width rules: the out-of-range compare is done at the full 23 bits. The RAM index is address[UAW-1:0], used only when in range.

Decomposition:
- Package fb_pkg:
  - FB_WIDTH, FB_HEIGHT, FB_DEPTH, FB_AW.
  - typedef logic [7:0] cell_t.
  - Cell type constants: CELL_EMPTY=8'h00, CELL_SAND=8'h01, CELL_WALL=8'h02, CELL_WATER=8'h03.
  - Render FSM enum rstate_t {IDLE, RESP}.
- Sub-module fb_ram: single-port synchronous RAM (cell_t data, FB_DEPTH words, registered q, write-first not required) so it infers M10K.

Test Plan:
- Write 8'h01 to upd_address 100, then read address 100 → waitrequest high in the first cycle, low in the second with readdata=8'h01.
- read at address 76800 → waitrequest=1 then 0, readdata=8'h00 (OOR_DATA), RAM untouched.
- read and upd_write to address 5 (value 8'h03, old value 8'h00) in the same cycle → read returns 8'h00, upd_waitrequest=1 for one cycle, write commits in RESP, a following read returns 8'h03.
- clear_start with no reads → clear_busy high for exactly 76800 cycles; reads at 0, 38400 and 76799 afterwards return 8'h00. Updates stall throughout.
- Continuous back-to-back reads during a clear → clear_busy duration extends by the number of IDLE-read cycles, and every read completes in 2 cycles.
- Assert reset in RESP and mid-clear → waitrequest=1, readdata=0, clear_busy=0 immediately (async); the next read completes normally.
